// File: rtl/spi_rx_deser.sv
// SPI receive deserialiser: bit-serial to SIZE-bit word with Valid/Ack holding register.
// Optional sticky overrun flag is compiled in when SPIRX_OVERRUN_EN is defined.
module spi_rx_deser #(
    parameter int SIZE      = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            En,
    input  logic            SerIn,
    input  logic            Clr,
    input  logic            Ack,
    output logic [SIZE-1:0] DataOut,
    output logic            Valid,
    output logic            Busy,
    output logic            Overrun
);

    localparam int CW = (SIZE > 2) ? $clog2(SIZE) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   cnt_next;
    logic [SIZE-2:0] sh_reg;
    logic [SIZE-2:0] sh_next;
    logic [SIZE-2:0] sh_keep;
    logic [SIZE-1:0] sh_full;
    logic [SIZE-1:0] data_reg;
    logic [SIZE-1:0] data_next;
    logic            valid_reg;
    logic            valid_next;
    logic            last_bit;
    logic            frame_done;
    logic [0:0]      state;

    // Only SIZE-1 bits of the shift register can ever hold data; the bit that
    // would be shifted out of the far end is never populated before completion.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign sh_full = {sh_reg, SerIn};
            assign sh_keep = sh_full[SIZE-2:0];
        end else begin : g_lsb_first
            assign sh_full = {SerIn, sh_reg};
            assign sh_keep = sh_full[SIZE-1:1];
        end
    endgenerate

    assign state      = (cnt_reg == '0) ? ST_IDLE : ST_SHIFT;
    assign last_bit   = (cnt_reg == CW'(SIZE - 1));
    assign frame_done = En & ~Clr & last_bit;

    always_comb begin
        cnt_next  = cnt_reg;
        sh_next   = sh_reg;
        data_next = data_reg;
        if (Clr) begin
            cnt_next = '0;
            sh_next  = '0;
        end else if (En) begin
            if (last_bit) begin
                cnt_next  = '0;
                sh_next   = '0;
                data_next = sh_full;
            end else begin
                cnt_next = cnt_reg + CW'(1);
                sh_next  = sh_keep;
            end
        end
    end

    // A completion in the same cycle as Ack wins: the Ack consumed the old word.
    always_comb begin
        valid_next = valid_reg;
        if (frame_done) begin
            valid_next = 1'b1;
        end else if (Ack) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_reg   <= '0;
            sh_reg    <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            sh_reg    <= sh_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
        end
    end

`ifdef SPIRX_OVERRUN_EN
    logic overrun_reg;
    logic overrun_next;

    always_comb begin
        overrun_next = overrun_reg;
        if (frame_done && valid_reg && !Ack) begin
            overrun_next = 1'b1;
        end else if (Ack) begin
            overrun_next = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= overrun_next;
        end
    end

    assign Overrun = overrun_reg;
`else
    assign Overrun = 1'b0;
`endif

    assign DataOut = data_reg;
    assign Valid   = valid_reg;
    assign Busy    = (state == ST_SHIFT);

endmodule

// File: tb/tb_spi_rx_deser.sv
// Randomized self-checking bench for spi_rx_deser; MSB-first and LSB-first
// instances share one stimulus stream and are checked against a frame-level model.
module tb_spi_rx_deser;

    localparam int SIZE = 8;
`ifdef SPIRX_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic            Clk = 1'b0;
    logic            Rst_n = 1'b0;
    logic            En = 1'b0;
    logic            SerIn = 1'b0;
    logic            Clr = 1'b0;
    logic            Ack = 1'b0;
    logic [SIZE-1:0] data_m;
    logic [SIZE-1:0] data_l;
    logic            valid_m, busy_m, ovr_m;
    logic            valid_l, busy_l, ovr_l;

    always #5 Clk = ~Clk;

    spi_rx_deser #(.SIZE(SIZE), .MSB_FIRST(1'b1)) u_dut_msb (
        .Clk(Clk), .Rst_n(Rst_n), .En(En), .SerIn(SerIn), .Clr(Clr), .Ack(Ack),
        .DataOut(data_m), .Valid(valid_m), .Busy(busy_m), .Overrun(ovr_m)
    );

    spi_rx_deser #(.SIZE(SIZE), .MSB_FIRST(1'b0)) u_dut_lsb (
        .Clk(Clk), .Rst_n(Rst_n), .En(En), .SerIn(SerIn), .Clr(Clr), .Ack(Ack),
        .DataOut(data_l), .Valid(valid_l), .Busy(busy_l), .Overrun(ovr_l)
    );

    // Reference model: a queue of received bits and the handshake flags.
    bit      q_bits[$];
    int      m_data_msb;
    int      m_data_lsb;
    bit      m_valid;
    bit      m_ovr;
    int      n_pass = 0;
    int      n_checks = 0;
    int      n_cycle = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, n_cycle, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        q_bits.delete();
        m_data_msb = 0;
        m_data_lsb = 0;
        m_valid    = 1'b0;
        m_ovr      = 1'b0;
    endtask

    task automatic model_step();
        bit done;
        done = 1'b0;
        if (Clr) begin
            q_bits.delete();
        end else if (En) begin
            q_bits.push_back(SerIn);
            if (q_bits.size() == SIZE) begin
                done       = 1'b1;
                m_data_msb = 0;
                m_data_lsb = 0;
                for (int i = 0; i < SIZE; i++) begin
                    m_data_msb = m_data_msb * 2 + int'(q_bits[i]);
                    m_data_lsb = m_data_lsb + (int'(q_bits[i]) << i);
                end
                q_bits.delete();
            end
        end
        if (done) begin
            if (m_valid && !Ack && OVR_EN) m_ovr = 1'b1;
            else if (Ack) m_ovr = 1'b0;
            m_valid = 1'b1;
        end else if (Ack) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic check_outputs();
        chk_eq("data_msb", 32'(data_m), 32'(m_data_msb));
        chk_eq("data_lsb", 32'(data_l), 32'(m_data_lsb));
        chk_eq("valid_msb", 32'(valid_m), 32'(m_valid));
        chk_eq("valid_lsb", 32'(valid_l), 32'(m_valid));
        chk_eq("busy_msb", 32'(busy_m), 32'(q_bits.size() != 0));
        chk_eq("busy_lsb", 32'(busy_l), 32'(q_bits.size() != 0));
        chk_eq("ovr_msb", 32'(ovr_m), 32'(m_ovr));
        chk_eq("ovr_lsb", 32'(ovr_l), 32'(m_ovr));
    endtask

    task automatic cycle(input bit en, input bit sin, input bit clr, input bit ack);
        En    = en;
        SerIn = sin;
        Clr   = clr;
        Ack   = ack;
        @(posedge Clk);
        n_cycle++;
        if (Rst_n) model_step();
        #1;
        check_outputs();
    endtask

    task automatic send_word(input logic [SIZE-1:0] w, input bit ack_last);
        for (int i = SIZE - 1; i >= 0; i--) begin
            cycle(1'b1, w[i], 1'b0, (i == 0) ? ack_last : 1'b0);
        end
    endtask

    initial begin
        logic [SIZE-1:0] w;
        model_reset();
        Rst_n = 1'b0;
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'(i % 2), 1'b0, 1'b0);
        Rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // 1,0,1,0,0,1,0,1 MSB-first
        send_word(8'hA5, 1'b0);
        chk_eq("a5_msb_word", 32'(data_m), 32'h0000_00A5);
        chk_eq("a5_busy_low", 32'(busy_m), 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk_eq("a5_ack_valid", 32'(valid_m), 32'h0);

        // 1,1,0,0,0,0,0,0 received LSB-first gives 8'h03
        send_word(8'hC0, 1'b0);
        chk_eq("lsb_03_word", 32'(data_l), 32'h0000_0003);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Abort after 3 bits; En bit during Clr discarded
        w = 8'hFF;
        for (int i = 0; i < 3; i++) cycle(1'b1, w[i], 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        chk_eq("clr_busy", 32'(busy_m), 32'h0);
        send_word(8'h3C, 1'b0);
        chk_eq("clr_3c_word", 32'(data_m), 32'h0000_003C);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Overrun: two unacknowledged frames
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        chk_eq("ovr_word", 32'(data_m), 32'h0000_0022);
        chk_eq("ovr_flag", 32'(ovr_m), 32'(OVR_EN));
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk_eq("ovr_ack_clear", 32'(ovr_m), 32'h0);

        // Ack on completion edge, with an idle gap mid-frame
        send_word(8'h11, 1'b0);
        w = 8'h22;
        for (int i = SIZE - 1; i >= 1; i--) begin
            cycle(1'b1, w[i], 1'b0, 1'b0);
            if (i == 4) for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        end
        cycle(1'b1, w[0], 1'b0, 1'b1);
        chk_eq("ackdone_valid", 32'(valid_m), 32'h1);
        chk_eq("ackdone_ovr", 32'(ovr_m), 32'h0);
        chk_eq("ackdone_word", 32'(data_m), 32'h0000_0022);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        Rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        #8;
        Rst_n = 1'b1;
        send_word(8'h5A, 1'b0);
        chk_eq("post_rst_word", 32'(data_m), 32'h0000_005A);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 4) != 0, 1'($urandom), ($urandom % 40) == 0, ($urandom % 6) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
